// File: rtl/regfile_pkg.sv
// regfile_pkg
//  Shared sizes, clear value and enums for the register-file write-port
//  controller (regfile_wr_ctrl), its interface and its round-robin arbiter.
//  Optional feature macro used elsewhere in this slice: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int          DW        = 8;        // data width, one regfile word
  localparam int          AW        = 3;        // register address width
  localparam int          NREG      = 1 << AW;  // number of registers (8)
  localparam logic [DW-1:0] CLEAR_VAL = 8'h00;  // value written to every register after reset

  // Controller phase: clearing the register file, or serving writebacks.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Requester that won the most recent write-port handshake.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// regfile_wr_ctrl_if
//  Bundles the two writeback requesters (ALU, load unit), the register-file
//  write pins and, with REGFILE_BYPASS_EN defined, the read-bypass signals.
//  Modports:
//    master : the execute/memory side plus the regfile model (drives requests,
//             raw read data and read addresses; observes readies and rf_* pins)
//    slave  : regfile_wr_ctrl
//  Signals:
//    alu_valid/alu_ready/alu_addr/alu_data : ALU writeback handshake
//    ld_valid/ld_ready/ld_addr/ld_data     : load-unit writeback handshake
//    rf_we/rf_wa/rf_wd                     : registered regfile write port
//    init_done                             : clear sequence has completed
//    ra/rb, rf_rd_a/rf_rd_b, rd_a/rd_b     : bypass read path (REGFILE_BYPASS_EN)
interface regfile_wr_ctrl_if;
  import regfile_pkg::*;

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          init_done;

`ifdef REGFILE_BYPASS_EN
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] rf_rd_a;
  logic [DW-1:0] rf_rd_b;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
`endif

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
`ifdef REGFILE_BYPASS_EN
    input  ra, rb, rf_rd_a, rf_rd_b,
    output rd_a, rd_b,
`endif
    output alu_ready, ld_ready,
    output rf_we, rf_wa, rf_wd, init_done
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
`ifdef REGFILE_BYPASS_EN
    output ra, rb, rf_rd_a, rf_rd_b,
    input  rd_a, rd_b,
`endif
    input  alu_ready, ld_ready,
    input  rf_we, rf_wa, rf_wd, init_done
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
//  Two-input round-robin arbiter, purely combinational.
//  Ports:
//    req[1:0]   in   request vector, bit 0 = ALU, bit 1 = load unit
//    last_grant in   requester that won the previous handshake
//    advance    in   arbitration enabled this cycle (controller in RUN, not in reset)
//    gnt[1:0]   out  one-hot grant, never set without the matching req bit
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  input  logic       advance,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      if (req == 2'b11) begin
        // Contention: the requester that did not win last time goes first.
        gnt = (last_grant == GNT_LD) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl
//  Write-port controller for the 8x8 register file. After reset it writes
//  CLEAR_VAL to every register (one per cycle), then shares the single write
//  port between the ALU and the load unit with round-robin arbitration.
//  The regfile pins rf_we/rf_wa/rf_wd are registered: a handshake at edge N
//  presents the write, and the regfile commits it at edge N+1.
//  Ports:
//    clk   in   rising-edge clock
//    rst   in   synchronous active-high reset; restarts the clear sequence
//    port  slave modport of regfile_wr_ctrl_if (requests, regfile pins,
//          init_done, and the bypass read path)
//  Optional feature: REGFILE_BYPASS_EN adds a combinational forward of the
//  pending write onto the two read ports (rd_a/rd_b).
module regfile_wr_ctrl
  import regfile_pkg::*;
(
  input logic             clk,
  input logic             rst,
  regfile_wr_ctrl_if.slave port
);

  state_e        state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
  grant_e        last_grant_reg, last_grant_next;
  logic          rf_we_reg, rf_we_next;
  logic [AW-1:0] rf_wa_reg, rf_wa_next;
  logic [DW-1:0] rf_wd_reg, rf_wd_next;
  logic          init_done_reg, init_done_next;

  logic [1:0]    gnt;
  logic          advance;

  // Readies are held low during reset so no handshake can complete while rst=1.
  assign advance = (state_reg == RUN) && !rst;

  rr_arb2 u_arb (
    .req        ({port.ld_valid, port.alu_valid}),
    .last_grant (last_grant_reg),
    .advance    (advance),
    .gnt        (gnt)
  );

  assign port.alu_ready = gnt[0];
  assign port.ld_ready  = gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= CLEAR;
      clr_cnt_reg    <= '0;
      last_grant_reg <= GNT_LD;   // ALU wins the first tie after reset
      rf_we_reg      <= 1'b0;
      rf_wa_reg      <= '0;
      rf_wd_reg      <= '0;
      init_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      last_grant_reg <= last_grant_next;
      rf_we_reg      <= rf_we_next;
      rf_wa_reg      <= rf_wa_next;
      rf_wd_reg      <= rf_wd_next;
      init_done_reg  <= init_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    last_grant_next = last_grant_reg;
    rf_we_next      = 1'b0;
    rf_wa_next      = rf_wa_reg;
    rf_wd_next      = rf_wd_reg;
    init_done_next  = init_done_reg;

    case (state_reg)
      CLEAR: begin
        rf_we_next   = 1'b1;
        rf_wa_next   = clr_cnt_reg;
        rf_wd_next   = CLEAR_VAL;
        clr_cnt_next = clr_cnt_reg + AW'(1);
        if (clr_cnt_reg == AW'(NREG - 1)) begin
          state_next     = RUN;
          init_done_next = 1'b1;
        end
      end
      RUN: begin
        if (gnt[0]) begin
          rf_we_next      = 1'b1;
          rf_wa_next      = port.alu_addr;
          rf_wd_next      = port.alu_data;
          last_grant_next = GNT_ALU;
        end else if (gnt[1]) begin
          rf_we_next      = 1'b1;
          rf_wa_next      = port.ld_addr;
          rf_wd_next      = port.ld_data;
          last_grant_next = GNT_LD;
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  assign port.rf_we     = rf_we_reg;
  assign port.rf_wa     = rf_wa_reg;
  assign port.rf_wd     = rf_wd_reg;
  assign port.init_done = init_done_reg;

`ifdef REGFILE_BYPASS_EN
  // Forward the write being committed this cycle so a same-cycle read sees
  // the new value (CLEAR_VAL while clearing).
  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_raw  [2];
  logic [DW-1:0] rd_fwd  [2];

  assign rd_addr[0] = port.ra;
  assign rd_addr[1] = port.rb;
  assign rd_raw[0]  = port.rf_rd_a;
  assign rd_raw[1]  = port.rf_rd_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
      assign rd_fwd[gi] = (rf_we_reg && (rf_wa_reg == rd_addr[gi])) ? rf_wd_reg : rd_raw[gi];
    end
  endgenerate

  assign port.rd_a = rd_fwd[0];
  assign port.rd_b = rd_fwd[1];
`endif

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl
//  Bench for regfile_wr_ctrl. A behavioural 8x8 regfile sits on the rf_*
//  pins. Expected writes are queued when a handshake is predicted and
//  compared when rf_we appears; readies are predicted from a round-robin
//  model of the requesters. Bypass checks are built with REGFILE_BYPASS_EN.
module tb_regfile_wr_ctrl;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_ctrl_if bus ();

  regfile_wr_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus)
  );

  // Regfile model
  logic [DW-1:0] mem [NREG];
  always @(posedge clk) begin
    if (bus.rf_we === 1'b1) mem[bus.rf_wa] <= bus.rf_wd;
  end

`ifdef REGFILE_BYPASS_EN
  assign bus.rf_rd_a = mem[bus.ra];
  assign bus.rf_rd_b = mem[bus.rb];
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  lg_model_ld = 1'b1;  // last grant was LD
  bit  run_model   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor: one line per regfile write, popped against the scoreboard.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      $display("write  wa=%0d wd=%02h", bus.rf_wa, bus.rf_wd);
      if (sb_q.size() == 0) begin
        check("unexpected_we", 32'(bus.rf_we), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rf_wa", 32'(bus.rf_wa), 32'(mon_e.a));
        check("rf_wd", 32'(bus.rf_wd), 32'(mon_e.d));
      end
    end
  end

  // One cycle of requester activity, starting and ending at a falling edge.
  task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd);
    logic ea, el;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.ld_valid  = lv; bus.ld_addr  = la; bus.ld_data  = ldd;
    #1;
    ea = run_model && !rst && av && (!lv || lg_model_ld);
    el = run_model && !rst && lv && !ea;
    check("alu_ready", 32'(bus.alu_ready), 32'(ea));
    check("ld_ready",  32'(bus.ld_ready),  32'(el));
    check("one_ready", 32'(bus.alu_ready & bus.ld_ready), 32'd0);
    if (ea) begin
      sb_q.push_back('{a: aa, d: ad});
      lg_model_ld = 1'b0;
      $display("grant  ALU R%0d=%02h", aa, ad);
    end else if (el) begin
      sb_q.push_back('{a: la, d: ldd});
      lg_model_ld = 1'b1;
      $display("grant  LD  R%0d=%02h", la, ldd);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Release reset and walk the 8-cycle clear with both requesters pushing.
  task automatic do_clear();
    rst = 1'b0;
    run_model   = 1'b0;
    lg_model_ld = 1'b1;
    for (int i = 0; i < NREG; i++) sb_q.push_back('{a: AW'(i), d: CLEAR_VAL});
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd7; bus.alu_data = 8'hE1;
    bus.ld_valid  = 1'b1; bus.ld_addr  = 3'd6; bus.ld_data  = 8'hE2;
    for (int i = 0; i < NREG; i++) begin
      #1;
      check("clr_alu_ready", 32'(bus.alu_ready), 32'd0);
      check("clr_ld_ready",  32'(bus.ld_ready),  32'd0);
      check("clr_init_done", 32'(bus.init_done), 32'd0);
      @(negedge clk);
    end
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    run_model = 1'b1;
    check("init_done", 32'(bus.init_done), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
`ifdef REGFILE_BYPASS_EN
    bus.ra = '0; bus.rb = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_we",        32'(bus.rf_we),     32'd0);
    check("rst_wa",        32'(bus.rf_wa),     32'd0);
    check("rst_wd",        32'(bus.rf_wd),     32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    // Requests during reset must not be accepted.
    cycle(1'b1, 3'd3, 8'h11, 1'b1, 3'd4, 8'h22);

    do_clear();

    // Single ALU write
    cycle(1'b1, 3'd3, 8'h55, 1'b0, '0, '0);
    idle();
    check("no_hs_we", 32'(bus.rf_we), 32'd0);
    check("r3", 32'(mem[3]), 32'h55);

    // Single load write, leaves LD as last grant
    cycle(1'b0, '0, '0, 1'b1, 3'd0, 8'h99);
    idle();
    check("r0", 32'(mem[0]), 32'h99);

    // Sustained contention: ALU, LD, ALU, LD
    repeat (4) cycle(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    idle();
    idle();
    check("r1", 32'(mem[1]), 32'h11);
    check("r2", 32'(mem[2]), 32'h22);

    // Same address from both: ALU first, LD second wins
    cycle(1'b1, 3'd5, 8'hAA, 1'b1, 3'd5, 8'hBB);
    cycle(1'b0, '0, '0, 1'b1, 3'd5, 8'hBB);
    idle();
    idle();
    check("r5", 32'(mem[5]), 32'hBB);

`ifdef REGFILE_BYPASS_EN
    cycle(1'b1, 3'd4, 8'h3C, 1'b0, '0, '0);
    bus.ra = 3'd4;
    bus.rb = 3'd2;
    #1;
    check("byp_rd_a", 32'(bus.rd_a), 32'h3C);
    check("byp_rd_b", 32'(bus.rd_b), 32'h22);
    idle();
    check("post_rd_a", 32'(bus.rd_a), 32'h3C);
`endif

    // Reset one cycle after an ALU handshake
    cycle(1'b1, 3'd6, 8'h66, 1'b0, '0, '0);
    rst = 1'b1;
    cycle(1'b1, 3'd6, 8'h77, 1'b1, 3'd2, 8'h33);
    check("rst_cancel_we", 32'(bus.rf_we), 32'd0);
    check("rst_init_low",  32'(bus.init_done), 32'd0);
    check("r6_committed",  32'(mem[6]), 32'h66);
    do_clear();
    idle();
    idle();
    check("r6_cleared", 32'(mem[6]), 32'(CLEAR_VAL));
    check("r5_cleared", 32'(mem[5]), 32'(CLEAR_VAL));
    check("sb_empty",   32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
